// File: rtl/error_propagator_seq.sv
`default_nettype none
// ============================================================================
// Module      : error_propagator_seq
// Description : Sequential back-propagation error stage. It collects a layer
//               index, a delta vector, an activation vector and a weight
//               matrix, each on its own handshake. For each row it then forms
//               r_i = ((sum_j delta_j*w(i,j)) >>> F) * a_i(1-a_i) >>> F,
//               using TILING_COL multipliers per cycle.
//               A transaction with layer 0 is discarded and flagged on 'error'.
// Options     : ERROR_PROPAGATOR_SATURATE_EN -- clamp each result cell and
//               drive a sticky 'overflow' flag (otherwise wrap, overflow = 0).
// Revision    : 1.0 - initial release
// ============================================================================
module error_propagator_seq #(
    parameter int MATRIX_WIDTH       = 4,
    parameter int MATRIX_HEIGHT      = 5,
    parameter int DELTA_CELL_WIDTH   = 12,
    parameter int WEIGHTS_CELL_WIDTH = 8,
    parameter int ACTIVATION_WIDTH   = 9,
    parameter int FRACTION_WIDTH     = 4,
    parameter int LAYER_ADDR_WIDTH   = 2,
    parameter int TILING_COL         = 3
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic [LAYER_ADDR_WIDTH-1:0]                               layer,
    input  logic                                                      layer_valid,
    output logic                                                      layer_ready,
    input  logic [MATRIX_WIDTH*DELTA_CELL_WIDTH-1:0]                  delta_input,
    input  logic                                                      delta_input_valid,
    output logic                                                      delta_input_ready,
    input  logic [MATRIX_HEIGHT*ACTIVATION_WIDTH-1:0]                 activation,
    input  logic                                                      activation_valid,
    output logic                                                      activation_ready,
    input  logic [MATRIX_WIDTH*MATRIX_HEIGHT*WEIGHTS_CELL_WIDTH-1:0]  w,
    input  logic                                                      w_valid,
    output logic                                                      w_ready,
    output logic [MATRIX_HEIGHT*DELTA_CELL_WIDTH-1:0]                 delta_output,
    output logic                                                      delta_output_valid,
    input  logic                                                      delta_output_ready,
    output logic                                                      error,
    output logic                                                      overflow
);

    localparam int DCW      = DELTA_CELL_WIDTH;
    localparam int WCW      = WEIGHTS_CELL_WIDTH;
    localparam int AW       = ACTIVATION_WIDTH;
    localparam int FW       = FRACTION_WIDTH;
    localparam int ONE      = 1 << FW;
    localparam int C_TILES  = (MATRIX_WIDTH + TILING_COL - 1) / TILING_COL;
    localparam int PAD_COLS = C_TILES * TILING_COL;
    localparam int PAD_IW   = (PAD_COLS > 1) ? $clog2(PAD_COLS) : 1;
    localparam int ROW_W    = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
    localparam int TILE_W   = $clog2(C_TILES + 1);
    localparam int PROD_W   = DCW + WCW;
    localparam int ACC_W    = DCW + WCW + $clog2(MATRIX_WIDTH) + 1;
    localparam int DER_W    = FW + 1;
    localparam int DP_W     = 2 * FW + 1;
    localparam int RES_W    = ACC_W + DER_W + 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                          state;
    logic                            got_layer, got_delta, got_act, got_w;
    logic [LAYER_ADDR_WIDTH-1:0]     layer_q;
    logic [MATRIX_WIDTH*DCW-1:0]     delta_q;
    logic [MATRIX_HEIGHT*AW-1:0]     act_q;
    logic [MATRIX_WIDTH*MATRIX_HEIGHT*WCW-1:0] w_q;
    logic [ROW_W-1:0]                row;
    logic [TILE_W-1:0]               tile;
    logic signed [ACC_W-1:0]         acc;
    logic signed [DCW-1:0]           out_cell [MATRIX_HEIGHT];

    // Handshake: a channel is ready only in COLLECT and only until captured
    assign layer_ready       = (state == COLLECT) && !got_layer;
    assign delta_input_ready = (state == COLLECT) && !got_delta;
    assign activation_ready  = (state == COLLECT) && !got_act;
    assign w_ready           = (state == COLLECT) && !got_w;

    logic layer_fire, delta_fire, act_fire, w_fire, all_in;
    logic [LAYER_ADDR_WIDTH-1:0] layer_eff;
    assign layer_fire = layer_valid && layer_ready;
    assign delta_fire = delta_input_valid && delta_input_ready;
    assign act_fire   = activation_valid && activation_ready;
    assign w_fire     = w_valid && w_ready;
    assign all_in     = (got_layer || layer_fire) && (got_delta || delta_fire) &&
                        (got_act || act_fire) && (got_w || w_fire);
    // The layer may arrive on the same edge that completes collection
    assign layer_eff  = layer_fire ? layer : layer_q;

    // Zero-padded operand views so the last tile of a row needs no special case
    logic signed [DCW-1:0] delta_pad [PAD_COLS];
    logic signed [WCW-1:0] w_pad     [MATRIX_HEIGHT][PAD_COLS];
    logic [AW-1:0]         act_cell  [MATRIX_HEIGHT];

    generate
        for (genvar j = 0; j < PAD_COLS; j++) begin : g_col
            if (j < MATRIX_WIDTH) begin : g_real
                assign delta_pad[j] = delta_q[j*DCW +: DCW];
                for (genvar i = 0; i < MATRIX_HEIGHT; i++) begin : g_wrow
                    assign w_pad[i][j] = w_q[(i*MATRIX_WIDTH + j)*WCW +: WCW];
                end
            end else begin : g_zero
                assign delta_pad[j] = '0;
                for (genvar i = 0; i < MATRIX_HEIGHT; i++) begin : g_wrow
                    assign w_pad[i][j] = '0;
                end
            end
        end
        for (genvar i = 0; i < MATRIX_HEIGHT; i++) begin : g_cell
            assign act_cell[i]                   = act_q[i*AW +: AW];
            assign delta_output[i*DCW +: DCW]    = out_cell[i];
        end
    endgenerate

    // Tile column select; held at tile 0 during the write cycle
    logic [TILE_W-1:0] tile_sel;
    assign tile_sel = (tile == TILE_W'(C_TILES)) ? '0 : tile;

    logic signed [PROD_W-1:0] prod [TILING_COL];
    generate
        for (genvar k = 0; k < TILING_COL; k++) begin : g_mult
            logic [PAD_IW-1:0] col;
            assign col     = PAD_IW'(tile_sel) * PAD_IW'(TILING_COL) + PAD_IW'(k);
            assign prod[k] = delta_pad[col] * w_pad[row][col];
        end
    endgenerate

    logic signed [ACC_W-1:0] tile_sum;
    // Add up the TILING_COL products of the current tile
    always_comb begin
        tile_sum = '0;
        for (int k = 0; k < TILING_COL; k++) begin
            tile_sum = tile_sum + ACC_W'(prod[k]);
        end
    end

    // Sigmoid-style derivative a*(1-a); zero once a reaches ONE
    logic [AW-1:0]    a_cur;
    logic [FW-1:0]    a_frac;
    logic [DER_W-1:0] one_minus;
    logic [DP_W-1:0]  der_prod;
    logic [DER_W-1:0] deriv;
    assign a_cur     = act_cell[row];
    assign a_frac    = a_cur[FW-1:0];
    assign one_minus = DER_W'(ONE) - DER_W'(a_frac);
    assign der_prod  = DP_W'(a_frac) * DP_W'(one_minus);
    assign deriv     = (a_cur >= AW'(ONE)) ? '0 : DER_W'(der_prod >> FW);

    // Row result before narrowing to the delta cell width
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [RES_W-1:0] res_full, res_sh;
    logic signed [DCW-1:0]   res_cell;
    assign acc_sh   = acc >>> FW;
    assign res_full = RES_W'(acc_sh) * RES_W'($signed({1'b0, deriv}));
    assign res_sh   = res_full >>> FW;

`ifdef ERROR_PROPAGATOR_SATURATE_EN
    localparam logic signed [RES_W-1:0] SAT_MAX = {{(RES_W-DCW+1){1'b0}}, {(DCW-1){1'b1}}};
    localparam logic signed [RES_W-1:0] SAT_MIN = ~SAT_MAX;
    logic sat_hi, sat_lo;
    assign sat_hi   = res_sh > SAT_MAX;
    assign sat_lo   = res_sh < SAT_MIN;
    assign res_cell = sat_hi ? DCW'(SAT_MAX) : (sat_lo ? DCW'(SAT_MIN) : DCW'(res_sh));
`else
    assign res_cell = DCW'(res_sh);
    assign overflow = 1'b0;
`endif

    // Control FSM with capture registers, row/tile sequencing and output regs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= COLLECT;
            got_layer          <= 1'b0;
            got_delta          <= 1'b0;
            got_act            <= 1'b0;
            got_w              <= 1'b0;
            layer_q            <= '0;
            delta_q            <= '0;
            act_q              <= '0;
            w_q                <= '0;
            row                <= '0;
            tile               <= '0;
            acc                <= '0;
            delta_output_valid <= 1'b0;
            error              <= 1'b0;
            for (int i = 0; i < MATRIX_HEIGHT; i++) begin
                out_cell[i] <= '0;
            end
`ifdef ERROR_PROPAGATOR_SATURATE_EN
            overflow           <= 1'b0;
`endif
        end else begin
            error <= 1'b0;
            case (state)
                COLLECT: begin
                    if (layer_fire) begin layer_q <= layer;       got_layer <= 1'b1; end
                    if (delta_fire) begin delta_q <= delta_input; got_delta <= 1'b1; end
                    if (act_fire)   begin act_q   <= activation;  got_act   <= 1'b1; end
                    if (w_fire)     begin w_q     <= w;           got_w     <= 1'b1; end
                    if (all_in) begin
                        if (layer_eff == '0) begin
                            // Input layer has no error to propagate: drop it
                            error     <= 1'b1;
                            got_layer <= 1'b0;
                            got_delta <= 1'b0;
                            got_act   <= 1'b0;
                            got_w     <= 1'b0;
                        end else begin
                            state <= COMPUTE;
                            row   <= '0;
                            tile  <= '0;
                            acc   <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (tile == TILE_W'(C_TILES)) begin
                        out_cell[row] <= res_cell;
`ifdef ERROR_PROPAGATOR_SATURATE_EN
                        if (sat_hi || sat_lo) overflow <= 1'b1;
`endif
                        acc  <= '0;
                        tile <= '0;
                        if (row == ROW_W'(MATRIX_HEIGHT - 1)) begin
                            row                <= '0;
                            state              <= HOLD;
                            delta_output_valid <= 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        acc  <= acc + tile_sum;
                        tile <= tile + 1'b1;
                    end
                end
                HOLD: begin
                    if (delta_output_ready) begin
                        state              <= COLLECT;
                        delta_output_valid <= 1'b0;
                        got_layer          <= 1'b0;
                        got_delta          <= 1'b0;
                        got_act            <= 1'b0;
                        got_w              <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
`default_nettype wire
